// File: rtl/cordic_pkg.sv
// Shared defaults and state encoding for the CORDIC request arbiter.
package cordic_pkg;

    localparam int WIDTH_DEF   = 15;
    localparam int LATENCY_DEF = 13;
    localparam int NREQ_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Delay line carrying {valid, requester id} in lockstep with the CORDIC pipeline.
module cordic_tag_pipe #(
    parameter int LATENCY = 13,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [ID_W-1:0] id_i,
    output logic            valid_o,
    output logic [ID_W-1:0] id_o
);

    logic [LATENCY-1:0] valid_q;
    logic [ID_W-1:0]    id_q [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) id_q[s] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            id_q[0]    <= id_i;
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                id_q[s]    <= id_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign id_o    = id_q[LATENCY-1];

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one CORDIC pipeline among NREQ requesters.
// States: IDLE = no granting, nothing pending | RUN = granting | DRAIN = waiting for in-flight tags.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int NREQ    = NREQ_DEF
) (
    input  logic                         CLK,
    input  logic                         RESET_n,
    input  logic                         en,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*2*WIDTH-1:0]      req_operand,
    output logic [NREQ-1:0]              req_ready,
    output logic [2*WIDTH-1:0]           cordic_operand,
    input  logic [2*WIDTH-1:0]           cordic_results,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [2*WIDTH-1:0]           rsp_data,
    output logic                         busy,
    output logic [$clog2(LATENCY+2)-1:0] inflight
);

    localparam int DW  = 2 * WIDTH;
    localparam int IDW = id_width(NREQ);
    localparam int CW  = $clog2(LATENCY + 2);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic [DW-1:0]   op_q;
    logic            op_valid_q;
    logic [IDW-1:0]  op_id_q;
    logic            tag_valid;
    logic [IDW-1:0]  tag_id;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;
    logic [CW-1:0]   inflight_q;

    // Grants only come from the registered RUN state and the live enable.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        if (RESET_n && state_q == RUN && en) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = IDW'((int'(ptr_q) + k) % NREQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_id    = cand;
                end
            end
        end
    end

    assign req_ready = grant_found ? (NREQ'(1) << grant_id) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)                    state_d = RUN;
                else if (inflight_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    cordic_tag_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (IDW)
    ) u_tag_pipe (
        .clk     (CLK),
        .rst_n   (RESET_n),
        .valid_i (op_valid_q),
        .id_i    (op_id_q),
        .valid_o (tag_valid),
        .id_o    (tag_id)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_q       <= grant_found ? req_operand[grant_id*DW +: DW] : '0;
            op_valid_q <= grant_found;
            op_id_q    <= grant_id;
            rsp_valid_q <= tag_valid ? (NREQ'(1) << tag_id) : '0;
            if (tag_valid) rsp_data_q <= cordic_results;
            case ({grant_found, tag_valid})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign cordic_operand = op_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign inflight       = inflight_q;
    assign busy           = RESET_n && (state_q != IDLE || inflight_q != '0);

endmodule
